// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for pipeline_controller: pipeline stage indices and the
// stall-cause encoding reported on stall_state.
package pipeline_controller_pkg;

    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;
    localparam int STAGE_WB  = 4;

    typedef enum logic [2:0] {
        STALL_RUN       = 3'd0,
        STALL_FLUSH     = 3'd1,
        STALL_LOAD_USE  = 3'd2,
        STALL_IMEM_WAIT = 3'd3,
        STALL_MEM_WAIT  = 3'd4,
        STALL_ALU_WAIT  = 3'd5
    } stall_cause_e;

endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently sitting in EX. x0 never creates a hazard.
module pipeline_controller_hazard_detect #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      ex_valid,
    input  logic                      ex_mem_read,
    input  logic                      ex_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    output logic                      load_use
);

    logic rd_live_s;
    logic rs1_hit_s;
    logic rs2_hit_s;

    // A load that never writes its rd cannot feed a dependent instruction.
    always_comb begin
        rd_live_s = ex_valid & ex_mem_read & ex_reg_write
                    & (ex_rd != {REG_ADDR_WIDTH{1'b0}});
        rs1_hit_s = id_uses_rs1 & (id_rs1 == ex_rd);
        rs2_hit_s = id_uses_rs2 & (id_rs2 == ex_rd);
        load_use  = rd_live_s & (rs1_hit_s | rs2_hit_s);
    end

endmodule

// File: rtl/pipeline_controller.sv
// Central stall/flush controller: stall-cause arbitration, per-register
// stall/flush vectors, instruction scoreboard and optional performance
// counters (enabled with the PIPELINE_PERF_COUNTERS_EN macro).
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int NUM_STAGES     = 5,
    parameter int REG_ADDR_WIDTH = 5
`ifdef PIPELINE_PERF_COUNTERS_EN
    ,
    parameter int COUNTER_WIDTH  = 32
`endif
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_uses_rs1,
    input  logic                      id_uses_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      ex_alu_busy,
    input  logic                      ex_should_branch,
    input  logic                      stall_l1i,
    input  logic                      stall_l1d,
    output logic [NUM_STAGES-1:0]     stage_stall,
    output logic [NUM_STAGES-1:0]     stage_flush,
    output logic [NUM_STAGES-1:0]     stage_valid,
    output logic [2:0]                stall_state,
    output logic                      retire
`ifdef PIPELINE_PERF_COUNTERS_EN
    ,
    output logic [COUNTER_WIDTH-1:0]  perf_cycles,
    output logic [COUNTER_WIDTH-1:0]  perf_retired,
    output logic [COUNTER_WIDTH-1:0]  perf_stall_cycles
`endif
);

    // Entry 1 is the IF/ID register (bubble tracking only); entries 2.. carry
    // the instruction fields captured from the ID decode outputs.
    logic [NUM_STAGES-1:1]     valid_q, valid_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q        [2:NUM_STAGES-1];
    logic [REG_ADDR_WIDTH-1:0] rd_d        [2:NUM_STAGES-1];
    logic                      mem_read_q  [2:NUM_STAGES-1];
    logic                      mem_read_d  [2:NUM_STAGES-1];
    logic                      reg_write_q [2:NUM_STAGES-1];
    logic                      reg_write_d [2:NUM_STAGES-1];

    stall_cause_e          cause_s;
    stall_cause_e          stall_state_q, stall_state_d;
    logic                  load_use_s;
    logic                  mem_wait_s;
    logic [NUM_STAGES-1:0] stall_s;
    logic [NUM_STAGES-1:0] flush_s;

    pipeline_controller_hazard_detect #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_hazard_detect (
        .ex_valid    (valid_q[STAGE_EX]),
        .ex_mem_read (mem_read_q[STAGE_EX]),
        .ex_reg_write(reg_write_q[STAGE_EX]),
        .ex_rd       (rd_q[STAGE_EX]),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .load_use    (load_use_s)
    );

    // Pick the single winning stall cause; a branch held in EX during
    // ALU_WAIT naturally wins the cycle busy drops.
    always_comb begin
        mem_wait_s = stall_l1d & valid_q[STAGE_MEM] & mem_read_q[STAGE_MEM];
        if (reset) begin
            cause_s = STALL_RUN;
        end else if (ex_alu_busy) begin
            cause_s = STALL_ALU_WAIT;
        end else if (mem_wait_s) begin
            cause_s = STALL_MEM_WAIT;
        end else if (ex_should_branch) begin
            cause_s = STALL_FLUSH;
        end else if (load_use_s) begin
            cause_s = STALL_LOAD_USE;
        end else if (stall_l1i) begin
            cause_s = STALL_IMEM_WAIT;
        end else begin
            cause_s = STALL_RUN;
        end
        stall_state_d = cause_s;
    end

    // Translate the winner into stall/flush bits per pipeline register.
    always_comb begin
        stall_s = {NUM_STAGES{1'b0}};
        flush_s = {NUM_STAGES{1'b0}};
        if (reset) begin
            flush_s = {NUM_STAGES{1'b1}};
        end else begin
            case (cause_s)
                STALL_ALU_WAIT: begin
                    stall_s[STAGE_EX:STAGE_IF] = 3'b111;
                    flush_s[STAGE_MEM]         = 1'b1;
                end
                STALL_MEM_WAIT: begin
                    stall_s[STAGE_MEM:STAGE_IF] = 4'b1111;
                    flush_s[STAGE_WB]           = 1'b1;
                end
                STALL_FLUSH: begin
                    flush_s[STAGE_EX:STAGE_ID] = 2'b11;
                end
                STALL_LOAD_USE: begin
                    stall_s[STAGE_ID:STAGE_IF] = 2'b11;
                    flush_s[STAGE_EX]          = 1'b1;
                end
                STALL_IMEM_WAIT: begin
                    stall_s[STAGE_IF] = 1'b1;
                    flush_s[STAGE_ID] = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Scoreboard advance: hold on stall, shift otherwise, flush kills valid.
    always_comb begin
        valid_d     = valid_q;
        rd_d        = rd_q;
        mem_read_d  = mem_read_q;
        reg_write_d = reg_write_q;

        if (flush_s[STAGE_ID]) begin
            valid_d[STAGE_ID] = 1'b0;
        end else if (stall_s[STAGE_ID]) begin
            valid_d[STAGE_ID] = valid_q[STAGE_ID];
        end else begin
            valid_d[STAGE_ID] = 1'b1;
        end

        if (flush_s[STAGE_EX]) begin
            valid_d[STAGE_EX] = 1'b0;
        end else if (stall_s[STAGE_EX]) begin
            valid_d[STAGE_EX] = valid_q[STAGE_EX];
        end else begin
            valid_d[STAGE_EX] = id_valid & valid_q[STAGE_ID];
        end
        if (stall_s[STAGE_EX]) begin
            rd_d[STAGE_EX] = rd_q[STAGE_EX];
        end else begin
            rd_d[STAGE_EX]        = id_rd;
            mem_read_d[STAGE_EX]  = id_mem_read;
            reg_write_d[STAGE_EX] = id_reg_write;
        end

        for (int i = STAGE_MEM; i < NUM_STAGES; i++) begin
            if (flush_s[i]) begin
                valid_d[i] = 1'b0;
            end else if (stall_s[i]) begin
                valid_d[i] = valid_q[i];
            end else begin
                valid_d[i] = valid_q[i-1];
            end
            if (stall_s[i]) begin
                rd_d[i] = rd_q[i];
            end else begin
                rd_d[i]        = rd_q[i-1];
                mem_read_d[i]  = mem_read_q[i-1];
                reg_write_d[i] = reg_write_q[i-1];
            end
        end
    end

    // Scoreboard and stall-cause registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q       <= {(NUM_STAGES-1){1'b0}};
            stall_state_q <= STALL_RUN;
            for (int i = STAGE_EX; i < NUM_STAGES; i++) begin
                rd_q[i]        <= {REG_ADDR_WIDTH{1'b0}};
                mem_read_q[i]  <= 1'b0;
                reg_write_q[i] <= 1'b0;
            end
        end else begin
            valid_q       <= valid_d;
            stall_state_q <= stall_state_d;
            rd_q          <= rd_d;
            mem_read_q    <= mem_read_d;
            reg_write_q   <= reg_write_d;
        end
    end

    assign stage_stall = stall_s;
    assign stage_flush = flush_s;
    assign stage_valid = {valid_q, 1'b1};
    assign stall_state = stall_state_q;
    assign retire      = valid_q[NUM_STAGES-1];

`ifdef PIPELINE_PERF_COUNTERS_EN
    logic [COUNTER_WIDTH-1:0] perf_cycles_q, perf_cycles_d;
    logic [COUNTER_WIDTH-1:0] perf_retired_q, perf_retired_d;
    logic [COUNTER_WIDTH-1:0] perf_stall_q, perf_stall_d;

    // Free-running counters; wrap naturally at 2^COUNTER_WIDTH.
    always_comb begin
        perf_cycles_d = perf_cycles_q + COUNTER_WIDTH'(1);
        if (retire) begin
            perf_retired_d = perf_retired_q + COUNTER_WIDTH'(1);
        end else begin
            perf_retired_d = perf_retired_q;
        end
        if (cause_s != STALL_RUN) begin
            perf_stall_d = perf_stall_q + COUNTER_WIDTH'(1);
        end else begin
            perf_stall_d = perf_stall_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_cycles_q  <= {COUNTER_WIDTH{1'b0}};
            perf_retired_q <= {COUNTER_WIDTH{1'b0}};
            perf_stall_q   <= {COUNTER_WIDTH{1'b0}};
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_retired_q <= perf_retired_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_cycles       = perf_cycles_q;
    assign perf_retired      = perf_retired_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller; perf-counter checks
// are compiled in when PIPELINE_PERF_COUNTERS_EN is defined.
module tb_pipeline_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
    logic       ex_alu_busy, ex_should_branch, stall_l1i, stall_l1d;
    logic [4:0] stage_stall, stage_flush, stage_valid;
    logic [2:0] stall_state;
    logic       retire;
`ifdef PIPELINE_PERF_COUNTERS_EN
    logic [31:0] perf_cycles, perf_retired, perf_stall_cycles;
`endif

    int compared   = 0;
    int mismatched = 0;

    pipeline_controller dut (
        .clock            (clock),
        .reset            (reset),
        .id_valid         (id_valid),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_uses_rs1      (id_uses_rs1),
        .id_uses_rs2      (id_uses_rs2),
        .id_rd            (id_rd),
        .id_reg_write     (id_reg_write),
        .id_mem_read      (id_mem_read),
        .ex_alu_busy      (ex_alu_busy),
        .ex_should_branch (ex_should_branch),
        .stall_l1i        (stall_l1i),
        .stall_l1d        (stall_l1d),
        .stage_stall      (stage_stall),
        .stage_flush      (stage_flush),
        .stage_valid      (stage_valid),
        .stall_state      (stall_state),
        .retire           (retire)
`ifdef PIPELINE_PERF_COUNTERS_EN
        ,
        .perf_cycles      (perf_cycles),
        .perf_retired     (perf_retired),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
        #1;
    endtask

    task automatic idle();
        ex_alu_busy = 1'b0; ex_should_branch = 1'b0; stall_l1i = 1'b0; stall_l1d = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        compared++; if (stage_flush !== 5'b11111) begin mismatched++; $display("FAIL rst_flush: got %b want %b", stage_flush, 5'b11111); end
        compared++; if (stage_stall !== 5'b00000) begin mismatched++; $display("FAIL rst_stall: got %b want %b", stage_stall, 5'b00000); end
        tick(); tick();
        compared++; if (stage_valid !== 5'b00001) begin mismatched++; $display("FAIL rst_valid: got %b want %b", stage_valid, 5'b00001); end
        compared++; if (stall_state !== 3'd0) begin mismatched++; $display("FAIL rst_state: got %0d want 0", stall_state); end
        compared++; if (retire !== 1'b0) begin mismatched++; $display("FAIL rst_retire: got %b want 0", retire); end
        reset = 1'b0;
        #1;
        compared++; if (stage_flush !== 5'b00000) begin mismatched++; $display("FAIL run_flush: got %b want %b", stage_flush, 5'b00000); end
        tick();
        compared++; if (stage_valid !== 5'b00011) begin mismatched++; $display("FAIL run_valid: got %b want %b", stage_valid, 5'b00011); end
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5,0(x1)
        compared++; if (stage_stall !== 5'b00000) begin mismatched++; $display("FAIL lu_load_stall: got %b want %b", stage_stall, 5'b00000); end
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x1
        compared++; if (stage_stall !== 5'b00011) begin mismatched++; $display("FAIL lu_stall: got %b want %b", stage_stall, 5'b00011); end
        compared++; if (stage_flush !== 5'b00100) begin mismatched++; $display("FAIL lu_flush: got %b want %b", stage_flush, 5'b00100); end
        tick();
        compared++; if (stall_state !== 3'd2) begin mismatched++; $display("FAIL lu_state: got %0d want 2", stall_state); end
        compared++; if (stage_valid !== 5'b01011) begin mismatched++; $display("FAIL lu_bubble: got %b want %b", stage_valid, 5'b01011); end
        compared++; if (stage_stall !== 5'b00000) begin mismatched++; $display("FAIL lu_single: got %b want %b", stage_stall, 5'b00000); end
        tick();
        compared++; if (stall_state !== 3'd0) begin mismatched++; $display("FAIL lu_state_run: got %0d want 0", stall_state); end
        compared++; if (retire !== 1'b1) begin mismatched++; $display("FAIL lu_load_retire: got %b want 1", retire); end
        idle();
        tick();
        compared++; if (retire !== 1'b0) begin mismatched++; $display("FAIL lu_gap_retire: got %b want 0", retire); end
        tick();
        compared++; if (retire !== 1'b1) begin mismatched++; $display("FAIL lu_add_retire: got %b want 1", retire); end
    endtask

    task automatic test_no_hazard();
        drain();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // lw x0
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x0,x1
        compared++; if (stage_stall !== 5'b00000) begin mismatched++; $display("FAIL x0_stall: got %b want %b", stage_stall, 5'b00000); end
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x1,x2
        compared++; if (stage_stall !== 5'b00000) begin mismatched++; $display("FAIL nodep_stall: got %b want %b", stage_stall, 5'b00000); end
        set_id(1'b1, 5'd5, 1'b0, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0);   // rs1 matches but unused
        compared++; if (stage_stall !== 5'b00000) begin mismatched++; $display("FAIL unused_rs1: got %b want %b", stage_stall, 5'b00000); end
        set_id(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);   // dependency via rs2
        compared++; if (stage_stall !== 5'b00011) begin mismatched++; $display("FAIL rs2_stall: got %b want %b", stage_stall, 5'b00011); end
        idle();
    endtask

    task automatic test_branch_imem();
        drain();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        ex_should_branch = 1'b1; stall_l1i = 1'b1;
        #1;
        compared++; if (stage_flush !== 5'b00110) begin mismatched++; $display("FAIL br_flush: got %b want %b", stage_flush, 5'b00110); end
        compared++; if (stage_stall !== 5'b00000) begin mismatched++; $display("FAIL br_stall: got %b want %b", stage_stall, 5'b00000); end
        tick();
        compared++; if (stall_state !== 3'd1) begin mismatched++; $display("FAIL br_state: got %0d want 1", stall_state); end
        compared++; if (stage_valid[2:0] !== 3'b001) begin mismatched++; $display("FAIL br_valid: got %b want %b", stage_valid[2:0], 3'b001); end
        idle();
        stall_l1i = 1'b1;
        #1;
        compared++; if (stage_stall !== 5'b00001) begin mismatched++; $display("FAIL im_stall: got %b want %b", stage_stall, 5'b00001); end
        compared++; if (stage_flush !== 5'b00010) begin mismatched++; $display("FAIL im_flush: got %b want %b", stage_flush, 5'b00010); end
        tick();
        compared++; if (stall_state !== 3'd3) begin mismatched++; $display("FAIL im_state: got %0d want 3", stall_state); end
        idle();
    endtask

    task automatic test_alu_busy();
        drain();
        ex_alu_busy = 1'b1; ex_should_branch = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            compared++; if (stage_stall !== 5'b00111) begin mismatched++; $display("FAIL alu_stall[%0d]: got %b want %b", c, stage_stall, 5'b00111); end
            compared++; if (stage_flush !== 5'b01000) begin mismatched++; $display("FAIL alu_flush[%0d]: got %b want %b", c, stage_flush, 5'b01000); end
            tick();
            compared++; if (stall_state !== 3'd5) begin mismatched++; $display("FAIL alu_state[%0d]: got %0d want 5", c, stall_state); end
        end
        ex_alu_busy = 1'b0;
        #1;
        compared++; if (stage_flush !== 5'b00110) begin mismatched++; $display("FAIL alu_br_flush: got %b want %b", stage_flush, 5'b00110); end
        compared++; if (stage_stall !== 5'b00000) begin mismatched++; $display("FAIL alu_br_stall: got %b want %b", stage_stall, 5'b00000); end
        tick();
        compared++; if (stall_state !== 3'd1) begin mismatched++; $display("FAIL alu_br_state: got %0d want 1", stall_state); end
        idle();
    endtask

    task automatic test_mem_wait_load_use();
        drain();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);   // lw x3
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);   // lw x7
        compared++; if (stage_stall !== 5'b00000) begin mismatched++; $display("FAIL mw_issue: got %b want %b", stage_stall, 5'b00000); end
        tick();
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);   // add x8,x7,x0
        stall_l1d = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            compared++; if (stage_stall !== 5'b01111) begin mismatched++; $display("FAIL mw_stall[%0d]: got %b want %b", c, stage_stall, 5'b01111); end
            compared++; if (stage_flush !== 5'b10000) begin mismatched++; $display("FAIL mw_flush[%0d]: got %b want %b", c, stage_flush, 5'b10000); end
            tick();
            compared++; if (stall_state !== 3'd4) begin mismatched++; $display("FAIL mw_state[%0d]: got %0d want 4", c, stall_state); end
        end
        stall_l1d = 1'b0;
        #1;
        compared++; if (stage_stall !== 5'b00011) begin mismatched++; $display("FAIL mw_lu_stall: got %b want %b", stage_stall, 5'b00011); end
        compared++; if (stage_flush !== 5'b00100) begin mismatched++; $display("FAIL mw_lu_flush: got %b want %b", stage_flush, 5'b00100); end
        tick();
        compared++; if (stall_state !== 3'd2) begin mismatched++; $display("FAIL mw_lu_state: got %0d want 2", stall_state); end
        compared++; if (retire !== 1'b1) begin mismatched++; $display("FAIL mw_retire: got %b want 1", retire); end
        compared++; if (stage_stall !== 5'b00000) begin mismatched++; $display("FAIL mw_no_double: got %b want %b", stage_stall, 5'b00000); end
        tick();
        compared++; if (stall_state !== 3'd0) begin mismatched++; $display("FAIL mw_run_state: got %0d want 0", stall_state); end
        compared++; if (stage_valid[2] !== 1'b1) begin mismatched++; $display("FAIL mw_add_ex: got %b want 1", stage_valid[2]); end
        idle();
    endtask

    task automatic test_reset_mid();
        drain();
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);   // lw x9
        tick();
        idle();
        tick();
        stall_l1d = 1'b1;
        #1;
        compared++; if (stage_stall !== 5'b01111) begin mismatched++; $display("FAIL rm_stall: got %b want %b", stage_stall, 5'b01111); end
        reset = 1'b1;
        #1;
        compared++; if (stage_flush !== 5'b11111) begin mismatched++; $display("FAIL rm_flush: got %b want %b", stage_flush, 5'b11111); end
        compared++; if (stage_stall !== 5'b00000) begin mismatched++; $display("FAIL rm_stall_clr: got %b want %b", stage_stall, 5'b00000); end
        tick();
        compared++; if (stage_valid !== 5'b00001) begin mismatched++; $display("FAIL rm_valid: got %b want %b", stage_valid, 5'b00001); end
        compared++; if (stall_state !== 3'd0) begin mismatched++; $display("FAIL rm_state: got %0d want 0", stall_state); end
        compared++; if (retire !== 1'b0) begin mismatched++; $display("FAIL rm_retire: got %b want 0", retire); end
`ifdef PIPELINE_PERF_COUNTERS_EN
        compared++; if (perf_cycles !== 32'd0) begin mismatched++; $display("FAIL rm_cycles: got %0d want 0", perf_cycles); end
        compared++; if (perf_retired !== 32'd0) begin mismatched++; $display("FAIL rm_retired: got %0d want 0", perf_retired); end
`endif
        reset = 1'b0;
        idle();
    endtask

`ifdef PIPELINE_PERF_COUNTERS_EN
    task automatic test_perf();
        tick();
        for (int n = 0; n < 10; n++) begin
            set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
            tick();
        end
        idle();
        for (int n = 0; n < 5; n++) tick();
        compared++; if (perf_retired !== 32'd10) begin mismatched++; $display("FAIL perf_retired: got %0d want 10", perf_retired); end
        compared++; if (perf_cycles !== 32'd16) begin mismatched++; $display("FAIL perf_cycles: got %0d want 16", perf_cycles); end
        compared++; if (perf_stall_cycles !== 32'd0) begin mismatched++; $display("FAIL perf_stall: got %0d want 0", perf_stall_cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_imem();
        test_alu_busy();
        test_mem_wait_load_use();
        test_reset_mid();
`ifdef PIPELINE_PERF_COUNTERS_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
